// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int DEFAULT_BIT_CYCLES = 208;
    localparam int CNT_W              = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; pointers carry one extra wrap bit to separate full from empty.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign rdata = mem_r[rptr_r[AW-1:0]];

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wptr_r[AW-1:0]] <= wdata;
                wptr_r                <= wptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM, sticky error flags and byte FIFO.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);

    logic             sync1_r;
    logic             rxs_r;
    rx_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             frame_err_r;
    logic             overrun_r;
    logic             cnt_zero_s;
    logic             push_s;
    logic             frame_set_s;
    logic             overrun_set_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;

    // Two-flop synchronizer, preset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rx;
            rxs_r   <= sync1_r;
        end
    end

    assign cnt_zero_s = (cnt_r == '0);

    // Stop-bit outcome; push is combinational so the byte lands on the stop-sample edge itself.
    always_comb begin
        push_s        = 1'b0;
        frame_set_s   = 1'b0;
        overrun_set_s = 1'b0;
        if ((state_r == ST_STOP) && cnt_zero_s) begin
            if (rxs_r) begin
                push_s        = 1'b1;
                overrun_set_s = fifo_full_s & ~rd_en;
            end else begin
                frame_set_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Receive FSM with bit timing counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rxs_r) begin
                        state_r <= ST_START;
                        cnt_r   <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (cnt_zero_s) begin
                        if (rxs_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r   <= ST_DATA;
                            cnt_r     <= FULL_LOAD;
                            bit_idx_r <= 3'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_zero_s) begin
                        shift_r[bit_idx_r] <= rxs_r;
                        cnt_r              <= FULL_LOAD;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_zero_s) begin
                        state_r <= rxs_r ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rxs_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (frame_set_s) begin
                frame_err_r <= 1'b1;
            end else if (clr_err) begin
                frame_err_r <= 1'b0;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_err) begin
                overrun_r <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .pop  (rd_en),
        .wdata(shift_r),
        .rdata(rd_data),
        .empty(fifo_empty_s),
        .full (fifo_full_s)
    );

    assign rd_valid  = ~fifo_empty_s;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: vector table, corner sequences and randomized frames vs a queue model.
module tb_uart_receiver;

    localparam int BC    = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       fe_m;
    logic       ov_m;

    typedef struct {
        logic [7:0] data;
        logic       stop_hi;
        logic       exp_valid;
        logic       exp_fe;
        logic       clr_after;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_receiver #(
        .BIT_CYCLES(BC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .clr_err  (clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives ncyc cycles of an 8N1 frame; lat = edges from start fall to first rd_valid=1.
    task automatic send_byte(input logic [7:0] b, input logic stop_hi, input int pop_k,
                             input int ncyc, output int lat);
        int pos;
        lat = -1;
        for (int k = 0; k < ncyc; k++) begin
            pos = k / BC;
            if (pos == 0) rx = 1'b0;
            else if (pos <= 8) rx = b[pos-1];
            else rx = stop_hi;
            rd_en = (k == pop_k);
            @(negedge clk);
            if (lat < 0 && rd_valid === 1'b1) lat = k + 1;
        end
        rd_en = 1'b0;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        int         lat;
        logic [7:0] b;
        logic       stop_hi;
        int         pop_k;
        int         sel;
        logic [7:0] exp4[4];

        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hA3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h0F, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_data", rd_data, 8'h00);
        chk("rst_fe", frame_err, 1'b0);
        chk("rst_ov", overrun, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].data, vecs[i].stop_hi, -1, 160, lat);
            chk("vec_valid", rd_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk("vec_latency", lat, 155);
                chk("vec_data", rd_data, vecs[i].data);
            end
            chk("vec_fe", frame_err, vecs[i].exp_fe);
            chk("vec_ov", overrun, 1'b0);
            if (!vecs[i].stop_hi) begin
                rx = 1'b0;
                repeat (40) @(negedge clk);
                rx = 1'b1;
                repeat (20) @(negedge clk);
                chk("break_nopush", rd_valid, 1'b0);
            end
            if (vecs[i].exp_valid) begin
                pop_one();
                chk("vec_pop_empty", rd_valid, 1'b0);
            end
            if (vecs[i].clr_after) begin
                pulse_clr();
                chk("vec_clr_fe", frame_err, 1'b0);
            end
            repeat (3) @(negedge clk);
        end

        // Short glitch on rx is a false start.
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_valid", rd_valid, 1'b0);
        chk("glitch_fe", frame_err, 1'b0);
        chk("glitch_ov", overrun, 1'b0);

        // Overrun: five bytes into a four-entry FIFO.
        for (int j = 1; j <= 5; j++) begin
            send_byte(8'(j), 1'b1, -1, 160, lat);
            if (j == 4) chk("full_no_ov", overrun, 1'b0);
        end
        chk("ov_set", overrun, 1'b1);
        chk("ov_fe", frame_err, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            chk("ov_pop_data", rd_data, 8'(j));
            pop_one();
        end
        chk("ov_drained", rd_valid, 1'b0);
        pop_one();
        chk("pop_empty_ignored", rd_valid, 1'b0);
        pulse_clr();
        chk("ov_clr", overrun, 1'b0);

        // Push and pop together while full.
        exp4 = '{8'h20, 8'h30, 8'h40, 8'h77};
        send_byte(8'h10, 1'b1, -1, 160, lat);
        send_byte(8'h20, 1'b1, -1, 160, lat);
        send_byte(8'h30, 1'b1, -1, 160, lat);
        send_byte(8'h40, 1'b1, -1, 160, lat);
        send_byte(8'h77, 1'b1, 154, 160, lat);
        chk("fullpp_ov", overrun, 1'b0);
        for (int j = 0; j < 4; j++) begin
            chk("fullpp_data", rd_data, exp4[j]);
            pop_one();
        end
        chk("fullpp_empty", rd_valid, 1'b0);

        // Reset mid-frame discards the frame and the FIFO contents.
        send_byte(8'h99, 1'b1, -1, 160, lat);
        chk("pre_rst_valid", rd_valid, 1'b1);
        send_byte(8'hC6, 1'b1, -1, 88, lat);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_valid", rd_valid, 1'b0);
        chk("midrst_data", rd_data, 8'h00);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("midrst_nopush", rd_valid, 1'b0);
        chk("midrst_fe", frame_err, 1'b0);
        send_byte(8'h3C, 1'b1, -1, 160, lat);
        chk("after_rst_lat", lat, 155);
        chk("after_rst_data", rd_data, 8'h3C);
        chk("after_rst_fe", frame_err, 1'b0);
        chk("after_rst_ov", overrun, 1'b0);
        pop_one();
        chk("after_rst_empty", rd_valid, 1'b0);

        // Randomized frames against a queue model.
        fe_m = 1'b0;
        ov_m = 1'b0;
        for (int n = 0; n < 30; n++) begin
            b       = 8'($urandom);
            stop_hi = ($urandom_range(0, 4) != 0);
            sel     = $urandom_range(0, 2);
            pop_k   = (sel == 0) ? -1 : ((sel == 1) ? 10 : 154);
            if (pop_k == 10 && q.size() > 0) void'(q.pop_front());
            send_byte(b, stop_hi, pop_k, 160, lat);
            if (stop_hi) begin
                if (pop_k == 154 && q.size() > 0) begin
                    void'(q.pop_front());
                    q.push_back(b);
                end else if (q.size() < DEPTH) begin
                    q.push_back(b);
                end else begin
                    ov_m = 1'b1;
                end
            end else begin
                fe_m = 1'b1;
                if (pop_k == 154 && q.size() > 0) void'(q.pop_front());
                rx = 1'b0;
                repeat (40) @(negedge clk);
                rx = 1'b1;
                repeat (20) @(negedge clk);
            end
            chk("rnd_valid", rd_valid, (q.size() != 0));
            if (q.size() != 0) chk("rnd_data", rd_data, q[0]);
            chk("rnd_fe", frame_err, fe_m);
            chk("rnd_ov", overrun, ov_m);
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                fe_m = 1'b0;
                ov_m = 1'b0;
                chk("rnd_clr_fe", frame_err, fe_m);
                chk("rnd_clr_ov", overrun, ov_m);
            end
        end
        while (q.size() > 0) begin
            chk("drain_data", rd_data, q[0]);
            void'(q.pop_front());
            pop_one();
        end
        chk("drain_empty", rd_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
